mc_datapath_core: RTL and testbench
===================================

// Module: mc_datapath_core
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle PC/ROM/regfile/ALU datapath.
//  Fetches 32-bit MIPS-style words over a req/ack instruction port.
//  Runs each instruction through FETCH/DECODE/EXEC/WB states.
//  Adds ADDI, SLT, HALT, an enable gate and an observable write-back strobe.
// PARAMETERS
//  DATA_W     32  register/ALU data width (>=16)
//  PC_W       32  program counter width; byte address, step 4
//  REG_ADDR_W 5   register address width; NUM_REGS = 2**REG_ADDR_W
// PORTS
//  clk        in   1           single clock; all state updates on rising edge
//  rst        in   1           synchronous reset, active-high
//  en         in   1           run enable, sampled only in FETCH before a request issues
//  imem_req   out  1           instruction fetch request
//  imem_addr  out  PC_W        word address = pc >> 2, stable while imem_req=1
//  imem_ack   in   1           fetch complete; imem_rdata valid this cycle
//  imem_rdata in   32          instruction word
//  pc_out     out  PC_W        current program counter
//  wb_valid   out  1           one-cycle pulse: register written this cycle
//  wb_addr    out  REG_ADDR_W  destination register of the write
//  wb_data    out  DATA_W      value written
//  halted     out  1           high once HALT has retired; sticky until rst
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - state=FETCH, pc=0, all registers=0.
//   - imem_req=0, wb_valid=0, wb_addr=0, wb_data=0, halted=0.
//   - Takes effect mid-fetch or mid-instruction; any outstanding req is abandoned, a late ack is ignored.
//  FETCH:
//   - If en=1 (or req already high): imem_req=1, hold req and addr until imem_ack.
//   - On ack: latch imem_rdata into IR, req=0, go to DECODE.
//   - en=0 with req low: remain idle.
//  DECODE: read rs=IR[25:21], rt=IR[20:16] into operand regs A,B; go to EXEC.
//   - Register fields are truncated to REG_ADDR_W LSBs.
//  EXEC: compute result R.
//   - IR==32'hFFFF_FFFF -> go to HALT.
//   - Else -> WB.
//  Decode table:
//   - R-type (IR[31:26]=0), funct IR[5:0], dest rd=IR[15:11]:
//     0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed, result 0/1).
//   - ADDI (opcode 0x08): dest rt; R = A + sign-extend(IR[15:0]) to DATA_W.
//   - Any other opcode/funct: NOP, no write.
//   - Arithmetic wraps modulo 2**DATA_W; no overflow trap.
//  WB:
//   - If instruction writes and dest!=0: update reg, wb_valid=1 for exactly this cycle, wb_addr/wb_data driven.
//   - Otherwise wb_valid=0 (reg 0 always reads 0).
//   - pc <= pc+4 (wraps modulo 2**PC_W); go to FETCH.
//   - wb_addr/wb_data hold last written value when wb_valid=0.
//  HALT: halted=1, pc not advanced, no further requests; exit only via rst.
//  Latency: ack in first FETCH cycle -> WB 3 cycles later; 4 cycles/instruction minimum.
//   - Each ack delay cycle adds one.
//  Read-after-write: value written in WB is visible to the next instruction's DECODE (no forwarding needed).
//  Simultaneous en fall and ack: the ack is consumed; en only blocks new requests.
// TESTING
//  - Reset: rst 2 cycles, en=1 -> next cycle imem_req=1, imem_addr=0, pc_out=0, halted=0.
//  - ADDI r1,r0,5 (0x20010005), ack same cycle -> wb_valid 3 cycles after ack, wb_addr=1, wb_data=5; pc_out=4.
//  - ADDI r2,r0,-3 then SUB r3,r1,r2 (0x00221822) -> wb_data=8 on r3; then SLT r4,r2,r1 (0x0041202A) -> wb_data=1.
//  - ADD r0,r1,r1 (0x00210020) -> no wb_valid, pc advances by 4; unknown funct 0x3F -> no wb_valid.
//  - Ack delayed 5 cycles with en dropped mid-wait -> imem_req/addr held stable, instruction retires; next fetch waits for en=1.
//  - Instruction 0xFFFFFFFF -> halted=1, imem_req stays 0, pc frozen; rst asserted mid-fetch -> pc_out=0, req=0 next cycle.

Source files
------------

// File: rtl/mc_datapath_core.sv
// Multi-cycle MIPS-style datapath: FETCH/DECODE/EXEC/WB over a req/ack instruction port.
// Supports ADD, SUB, AND, OR, SLT, ADDI and HALT with an observable write-back strobe.
module mc_datapath_core #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [PC_W-1:0]       pc_out,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  halted
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StHalt} state_e;

  state_e                  state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [31:0]             ir_q, ir_d;
  logic [DATA_W-1:0]       a_q, a_d, b_q, b_d;
  logic                    pend_q, pend_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]       wb_data_q, wb_data_d;
  logic [DATA_W-1:0]       regs_q [NumRegs];
  logic                    rf_we;

  logic [5:0]              opcode, funct;
  logic [REG_ADDR_W-1:0]   rs, rt, rd, dest;
  logic [DATA_W-1:0]       imm_ext, result;
  logic                    writes;
  logic                    unused_shamt;

  assign opcode       = ir_q[31:26];
  assign funct        = ir_q[5:0];
  assign rs           = ir_q[21 +: REG_ADDR_W];
  assign rt           = ir_q[16 +: REG_ADDR_W];
  assign rd           = ir_q[11 +: REG_ADDR_W];
  assign imm_ext      = {{(DATA_W - 16){ir_q[15]}}, ir_q[15:0]};
  assign unused_shamt = ^ir_q[10:6];

  always_comb begin
    result = '0;
    writes = 1'b0;
    dest   = rd;
    if (opcode == 6'h00) begin
      writes = 1'b1;
      case (funct)
        6'h20:   result = a_q + b_q;
        6'h22:   result = a_q - b_q;
        6'h24:   result = a_q & b_q;
        6'h25:   result = a_q | b_q;
        6'h2A:   result = DATA_W'($signed(a_q) < $signed(b_q));
        default: writes = 1'b0;
      endcase
    end else if (opcode == 6'h08) begin
      writes = 1'b1;
      dest   = rt;
      result = a_q + imm_ext;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    pend_d     = pend_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    imem_req   = 1'b0;
    rf_we      = 1'b0;
    unique case (state_q)
      StFetch: begin
        // Once a request is out, it stays out until acked even if en falls.
        imem_req = !rst && (en || pend_q);
        if (imem_req) begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            pend_d  = 1'b0;
            state_d = StDecode;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      StDecode: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        state_d = StExec;
      end
      StExec: begin
        if (ir_q == 32'hFFFF_FFFF) begin
          state_d = StHalt;
        end else begin
          state_d    = StWb;
          wb_valid_d = writes && (dest != '0);
          if (writes && (dest != '0)) begin
            wb_addr_d = dest;
            wb_data_d = result;
          end
        end
      end
      StWb: begin
        rf_we      = wb_valid_q;
        wb_valid_d = 1'b0;
        pc_d       = pc_q + PC_W'(4);
        state_d    = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pend_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pend_q     <= pend_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      if (rf_we) regs_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign imem_addr = pc_q >> 2;
  assign pc_out    = pc_q;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_mc_datapath_core.sv
// Directed bench for mc_datapath_core: hand-encoded instructions with hand-computed results.
module tb_mc_datapath_core;

  logic        clk = 1'b0;
  logic        rst, en, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, wb_valid, halted;
  logic [31:0] imem_addr, pc_out, wb_data;
  logic [4:0]  wb_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_pc;

  mc_datapath_core #(
    .DATA_W    (32),
    .PC_W      (32),
    .REG_ADDR_W(5)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .pc_out    (pc_out),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Waits for a request, optionally delays the ack (dropping en mid-wait), then follows the
  // instruction through to write-back. Inputs change and outputs are sampled on negedge.
  task automatic run_instr(input string tag, input logic [31:0] instr, input int delay,
                           input bit drop_en, input bit exp_wb, input logic [4:0] exp_addr,
                           input logic [31:0] exp_data);
    int waited = 0;
    while (!imem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, " req"}, 32'(imem_req), 32'd1);
    check_eq({tag, " addr"}, imem_addr, exp_pc >> 2);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (drop_en && i == 1) en = 1'b0;
      check_eq({tag, " req held"}, 32'(imem_req), 32'd1);
      check_eq({tag, " addr held"}, imem_addr, exp_pc >> 2);
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq({tag, " no early wb"}, 32'(wb_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, " wb_valid"}, 32'(wb_valid), 32'(exp_wb));
    if (exp_wb) begin
      check_eq({tag, " wb_addr"}, 32'(wb_addr), 32'(exp_addr));
      check_eq({tag, " wb_data"}, wb_data, exp_data);
    end
    @(negedge clk);
    exp_pc = exp_pc + 32'd4;
    check_eq({tag, " pc"}, pc_out, exp_pc);
    check_eq({tag, " wb pulse"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exp_pc     = '0;
    repeat (2) @(negedge clk);
    check_eq("rst wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst wb_addr", 32'(wb_addr), 32'd0);
    check_eq("rst wb_data", wb_data, 32'd0);
    check_eq("rst halted", 32'(halted), 32'd0);
    check_eq("rst pc", pc_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post-rst req", 32'(imem_req), 32'd1);
    check_eq("post-rst addr", imem_addr, 32'd0);

    run_instr("addi r1", 32'h2001_0005, 0, 1'b0, 1'b1, 5'd1, 32'd5);
    run_instr("addi r2", 32'h2002_FFFD, 0, 1'b0, 1'b1, 5'd2, 32'hFFFF_FFFD);
    run_instr("sub r3",  32'h0022_1822, 0, 1'b0, 1'b1, 5'd3, 32'd8);
    run_instr("slt r4",  32'h0041_202A, 1, 1'b0, 1'b1, 5'd4, 32'd1);
    run_instr("add r0",  32'h0021_0020, 0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("hold wb_addr", 32'(wb_addr), 32'd4);
    check_eq("hold wb_data", wb_data, 32'd1);
    run_instr("funct3f", 32'h0021_283F, 0, 1'b0, 1'b0, 5'd0, 32'd0);
    run_instr("and r5",  32'h0023_2824, 0, 1'b0, 1'b1, 5'd5, 32'd0);
    run_instr("or r6",   32'h0023_3025, 2, 1'b0, 1'b1, 5'd6, 32'd13);
    run_instr("add r7",  32'h0064_3820, 5, 1'b1, 1'b1, 5'd7, 32'd9);

    repeat (3) begin
      check_eq("en low idle req", 32'(imem_req), 32'd0);
      check_eq("en low pc", pc_out, exp_pc);
      @(negedge clk);
    end
    en = 1'b1;
    run_instr("slt r8",  32'h0022_402A, 0, 1'b0, 1'b1, 5'd8, 32'd0);
    run_instr("addi r9", 32'h2049_0003, 0, 1'b0, 1'b1, 5'd9, 32'd0);

    // HALT
    check_eq("halt req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    repeat (4) begin
      check_eq("halted", 32'(halted), 32'd1);
      check_eq("halt no req", 32'(imem_req), 32'd0);
      check_eq("halt pc", pc_out, exp_pc);
      check_eq("halt no wb", 32'(wb_valid), 32'd0);
      @(negedge clk);
    end

    // Reset from halt, then reset again mid-fetch with a pending request.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = '0;
    @(negedge clk);
    check_eq("unhalt", 32'(halted), 32'd0);
    check_eq("midfetch req", 32'(imem_req), 32'd1);
    en = 1'b0;
    @(negedge clk);
    check_eq("pending req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst2 req", 32'(imem_req), 32'd0);
    check_eq("rst2 pc", pc_out, 32'd0);
    check_eq("rst2 wb_addr", 32'(wb_addr), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h2001_0005;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check_eq("late ack req", 32'(imem_req), 32'd0);
    check_eq("late ack pc", pc_out, 32'd0);
    check_eq("late ack wb", 32'(wb_valid), 32'd0);
    en = 1'b1;
    // Registers were cleared, so r1+r2 must be 0.
    run_instr("add r10", 32'h0022_5020, 0, 1'b0, 1'b1, 5'd10, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
